// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sound ids, FSM states and per-sound tone/duration tables
//
// Index convention: pending/request bit i corresponds to sound id i+1.
//   bit 0 KEYX, 1 KEYY, 2 ENTER, 3 BORDER, 4 BALL, 5 HOLE (higher index = higher priority)
package audio_pkg;

  localparam int NUM_SND = 6;

  typedef enum logic [2:0] {
    SND_NONE   = 3'd0,
    SND_KEYX   = 3'd1,
    SND_KEYY   = 3'd2,
    SND_ENTER  = 3'd3,
    SND_BORDER = 3'd4,
    SND_BALL   = 3'd5,
    SND_HOLE   = 3'd6
  } snd_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  // Note index handed to the tone generator, by request index.
  localparam logic [3:0] TONE_TABLE [NUM_SND] = '{4'd2, 4'd3, 4'd7, 4'd5, 4'd9, 4'd12};

  // Sound length in duration ticks, by request index.
  localparam int DUR_TABLE [NUM_SND] = '{30, 30, 120, 40, 60, 300};

  function automatic snd_id_t snd_of(input logic [2:0] idx);
    return snd_id_t'(idx + 3'd1);
  endfunction

endpackage

// File: rtl/audio_request_sequencer_if.sv
// rtl/audio_request_sequencer_if.sv - request lines and tone stream bundle
//
// Signals:
//   *AudioRequest   six level request lines from the sound request mux
//   tone_enable     high while a sound plays
//   tone_code       note index, valid while tone_enable
//   sound_id        id of the playing sound (snd_id_t), 0 otherwise
//   busy            high while a sound or its trailing gap is in progress
//   pending         latched, not yet served request events (debug)
// Modports:
//   master  requester side: drives requests, observes the tone stream
//   slave   sequencer side: samples requests, drives the tone stream
interface audio_request_sequencer_if;

  logic       keyXAudioRequest;
  logic       keyYAudioRequest;
  logic       keyEnterAudioRequest;
  logic       holeColAudioRequest;
  logic       borderColAudioRequest;
  logic       ballToBallColAudioRequest;

  logic       tone_enable;
  logic [3:0] tone_code;
  logic [2:0] sound_id;
  logic       busy;
  logic [5:0] pending;

  modport master (
    output keyXAudioRequest, keyYAudioRequest, keyEnterAudioRequest,
           holeColAudioRequest, borderColAudioRequest, ballToBallColAudioRequest,
    input  tone_enable, tone_code, sound_id, busy, pending
  );

  modport slave (
    input  keyXAudioRequest, keyYAudioRequest, keyEnterAudioRequest,
           holeColAudioRequest, borderColAudioRequest, ballToBallColAudioRequest,
    output tone_enable, tone_code, sound_id, busy, pending
  );

endinterface

// File: rtl/audio_prio_encoder.sv
// rtl/audio_prio_encoder.sv - 6-bit fixed-priority encoder, highest index wins
//
// Ports:
//   req    in  6  request bitmap
//   valid  out 1  any bit set
//   idx    out 3  index of the highest set bit (0 when none)
module audio_prio_encoder (
  input  logic [5:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  // Ascending scan: the last set bit seen is the highest priority one.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/audio_request_sequencer.sv
// rtl/audio_request_sequencer.sv - serializes audio request edges into one tone stream
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   bus    slave side of audio_request_sequencer_if (requests in, tone stream out)
// Parameters:
//   TICK_DIV   clocks per duration tick (>= 2)
//   GAP_TICKS  silent ticks after every sound
//   DUR_W      duration counter width, must hold the largest DUR_TABLE entry
// Build option:
//   AUDIO_PREEMPT_EN  a strictly higher-priority pending event aborts the playing sound
module audio_request_sequencer #(
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 20,
  parameter int DUR_W     = 10
) (
  input logic                     clk,
  input logic                     reset,
  audio_request_sequencer_if.slave bus
);

  import audio_pkg::*;

  localparam int              PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  seq_state_t       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       req, req_q, pend_q, clr;
  logic             enc_valid, load, preempt, tick, play;
  logic [2:0]       enc_idx;

  assign req = {bus.holeColAudioRequest, bus.ballToBallColAudioRequest,
                bus.borderColAudioRequest, bus.keyEnterAudioRequest,
                bus.keyYAudioRequest, bus.keyXAudioRequest};

  audio_prio_encoder u_prio (
    .req   (pend_q),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

`ifdef AUDIO_PREEMPT_EN
  assign preempt = (state_q == ST_PLAY) && enc_valid && (enc_idx > idx_q);
`else
  assign preempt = 1'b0;
`endif

  assign load = ((state_q == ST_IDLE) && enc_valid) || preempt;
  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    pre_d   = pre_q;
    clr     = 6'd0;
    if (load) begin
      // Served (or preempting) event leaves pending; the aborted sound is simply dropped.
      clr     = 6'd1 << enc_idx;
      idx_d   = enc_idx;
      dur_d   = DUR_W'(DUR_TABLE[enc_idx]);
      pre_d   = '0;
      state_d = ST_PLAY;
    end else if (state_q != ST_IDLE) begin
      // PLAY and GAP share the prescaler/tick countdown; only the follow-on state differs.
      if (tick) begin
        pre_d = '0;
        if (dur_q <= DUR_W'(1)) begin
          if (state_q == ST_PLAY) begin
            dur_d   = DUR_W'(GAP_TICKS);
            state_d = ST_GAP;
          end else begin
            dur_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
          dur_d = dur_q - DUR_W'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      dur_q   <= '0;
      pre_q   <= '0;
      req_q   <= 6'd0;
      pend_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      pre_q   <= pre_d;
      req_q   <= req;
      // A new edge on a bit being served this cycle keeps it pending (replays later).
      pend_q  <= (pend_q & ~clr) | (req & ~req_q);
    end
  end

  // Outputs decode registered state only, so they change one edge after the decision.
  assign play            = (state_q == ST_PLAY);
  assign bus.tone_enable = play;
  assign bus.tone_code   = play ? TONE_TABLE[idx_q] : 4'd0;
  assign bus.sound_id    = play ? snd_of(idx_q) : SND_NONE;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.pending     = pend_q;

endmodule

// File: tb/tb_audio_request_sequencer.sv
// tb/tb_audio_request_sequencer.sv - self-checking bench for audio_request_sequencer (honours AUDIO_PREEMPT_EN)
module tb_audio_request_sequencer;

  localparam int TD = 4;
  localparam int GT = 2;
`ifdef AUDIO_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req;

  always #5 clk = ~clk;

  audio_request_sequencer_if bus ();

  assign bus.keyXAudioRequest          = req[0];
  assign bus.keyYAudioRequest          = req[1];
  assign bus.keyEnterAudioRequest      = req[2];
  assign bus.borderColAudioRequest     = req[3];
  assign bus.ballToBallColAudioRequest = req[4];
  assign bus.holeColAudioRequest       = req[5];

  audio_request_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT), .DUR_W(10)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sound-level model: whole-sound cycle counts, no prescaler.
  int m_dur  [6] = '{30, 30, 120, 40, 60, 300};
  int m_tone [6] = '{2, 3, 7, 5, 9, 12};
  typedef enum {M_IDLE, M_PLAY, M_GAP} m_phase_t;
  m_phase_t   m_phase = M_IDLE;
  int         m_cur = 0, m_left = 0, m_top;
  logic [5:0] m_pend = 6'd0, m_prev = 6'd0, m_clr;

  function automatic int highest(input logic [5:0] v);
    for (int i = 5; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = M_IDLE; m_cur = 0; m_left = 0; m_pend = 6'd0; m_prev = 6'd0;
    end else begin
      m_top = highest(m_pend);
      m_clr = 6'd0;
      if ((m_phase == M_IDLE && m_top >= 0) || (PREEMPT && m_phase == M_PLAY && m_top > m_cur)) begin
        m_clr   = 6'd1 << m_top;
        m_cur   = m_top;
        m_left  = m_dur[m_top] * TD;
        m_phase = M_PLAY;
      end else if (m_phase != M_IDLE) begin
        m_left--;
        if (m_left == 0) begin
          if (m_phase == M_PLAY) begin
            m_phase = M_GAP;
            m_left  = GT * TD;
          end else begin
            m_phase = M_IDLE;
          end
        end
      end
      m_pend = (m_pend & ~m_clr) | (req & ~m_prev);
      m_prev = req;
    end
  end

  // Per-cycle compare plus a segment recorder for the literal expectations.
  bit chk_en = 0, rec_en = 0;
  int rec_cnt, p_sid;
  bit p_te, p_gap;
  int s_id[$], s_code[$], s_len[$], s_start[$], g_len[$];
  int e_id[$], e_code[$], e_len[$], e_start[$];

  initial forever begin
    @(posedge clk);
    #3;
    if (chk_en) begin
      chk("tone_enable", int'(bus.tone_enable), int'(m_phase == M_PLAY));
      if (m_phase == M_PLAY) chk("tone_code", int'(bus.tone_code), m_tone[m_cur]);
      chk("sound_id", int'(bus.sound_id), (m_phase == M_PLAY) ? m_cur + 1 : 0);
      chk("busy", int'(bus.busy), int'(m_phase != M_IDLE));
      chk("pending", int'(bus.pending), int'(m_pend));
    end
    if (rec_en) begin
      if (bus.tone_enable) begin
        if (!p_te || int'(bus.sound_id) != p_sid) begin
          s_id.push_back(int'(bus.sound_id));
          s_code.push_back(int'(bus.tone_code));
          s_len.push_back(1);
          s_start.push_back(rec_cnt);
        end else begin
          s_len[s_len.size()-1] += 1;
        end
      end
      if (bus.busy && !bus.tone_enable) begin
        if (!p_gap) g_len.push_back(1);
        else g_len[g_len.size()-1] += 1;
      end
      p_te    = bus.tone_enable;
      p_sid   = int'(bus.sound_id);
      p_gap   = bus.busy && !bus.tone_enable;
      rec_cnt = rec_cnt + 1;
    end
  end

  task automatic start_rec();
    s_id.delete(); s_code.delete(); s_len.delete(); s_start.delete(); g_len.delete();
    e_id.delete(); e_code.delete(); e_len.delete(); e_start.delete();
    rec_cnt = 0; p_te = 0; p_sid = 0; p_gap = 0;
    rec_en  = 1;
  endtask

  task automatic exp_seg(input int id, input int code, input int len, input int start);
    e_id.push_back(id); e_code.push_back(code); e_len.push_back(len); e_start.push_back(start);
  endtask

  task automatic check_segs(input string tag, input int ngaps);
    chk($sformatf("%s sound count", tag), s_id.size(), e_id.size());
    for (int i = 0; i < e_id.size() && i < s_id.size(); i++) begin
      chk($sformatf("%s s%0d id", tag, i), s_id[i], e_id[i]);
      chk($sformatf("%s s%0d code", tag, i), s_code[i], e_code[i]);
      chk($sformatf("%s s%0d len", tag, i), s_len[i], e_len[i]);
      chk($sformatf("%s s%0d start", tag, i), s_start[i], e_start[i]);
    end
    chk($sformatf("%s gap count", tag), g_len.size(), ngaps);
    for (int i = 0; i < g_len.size(); i++) chk($sformatf("%s g%0d len", tag, i), g_len[i], 8);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 6'd0;
    cycles(2);
    chk("reset tone_enable", int'(bus.tone_enable), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset pending", int'(bus.pending), 0);
    chk("reset sound_id", int'(bus.sound_id), 0);
    chk_en = 1;
    rst    = 1'b0;
    cycles(2);

    // Single HOLE pulse.
    start_rec();
    req[5] = 1'b1; cycles(1); req[5] = 1'b0;
    cycles(1300);
    rec_en = 0;
    exp_seg(6, 12, 1200, 1);
    check_segs("single", 1);
    chk("single idle busy", int'(bus.busy), 0);

    // Held KEYX level: one event only.
    start_rec();
    req[0] = 1'b1; cycles(5000); req[0] = 1'b0;
    cycles(20);
    rec_en = 0;
    exp_seg(1, 2, 120, 1);
    check_segs("held", 1);

    // BORDER + ENTER + KEYX on one edge.
    start_rec();
    req = 6'b001101; cycles(1); req = 6'd0;
    cycles(900);
    rec_en = 0;
    exp_seg(4, 5, 160, 1);
    exp_seg(3, 7, 480, 170);
    exp_seg(1, 2, 120, 659);
    check_segs("simul", 3);

    // KEYY re-request while KEYY plays -> one replay.
    start_rec();
    req[1] = 1'b1; cycles(1); req[1] = 1'b0;
    cycles(20);
    req[1] = 1'b1; cycles(1); req[1] = 1'b0;
    cycles(300);
    rec_en = 0;
    exp_seg(2, 3, 120, 1);
    exp_seg(2, 3, 120, 130);
    check_segs("replay", 2);

    // Two KEYY edges while HOLE plays -> merged into one.
    start_rec();
    req[5] = 1'b1; cycles(1); req[5] = 1'b0;
    cycles(50);
    req[1] = 1'b1; cycles(1); req[1] = 1'b0;
    cycles(50);
    req[1] = 1'b1; cycles(1); req[1] = 1'b0;
    cycles(1400);
    rec_en = 0;
    exp_seg(6, 12, 1200, 1);
    exp_seg(2, 3, 120, 1210);
    check_segs("merge", 2);

    // Reset during cycle 50 of HOLE with KEYX pending.
    start_rec();
    req[5] = 1'b1; cycles(1); req[5] = 1'b0;
    cycles(20);
    req[0] = 1'b1; cycles(1); req[0] = 1'b0;
    cycles(29);
    rst = 1'b1;
    cycles(1);
    chk("mid reset tone_enable", int'(bus.tone_enable), 0);
    chk("mid reset busy", int'(bus.busy), 0);
    chk("mid reset pending", int'(bus.pending), 0);
    rst = 1'b0;
    rec_en = 0;
    exp_seg(6, 12, 50, 1);
    check_segs("reset cut", 0);
    start_rec();
    cycles(300);
    rec_en = 0;
    check_segs("after reset", 0);

    // BALL edge during cycle 10 of KEYX.
    start_rec();
    req[0] = 1'b1; cycles(1); req[0] = 1'b0;
    cycles(10);
    req[4] = 1'b1; cycles(1); req[4] = 1'b0;
    cycles(500);
    rec_en = 0;
    if (PREEMPT) begin
      exp_seg(1, 2, 11, 1);
      exp_seg(5, 9, 240, 12);
    end else begin
      exp_seg(1, 2, 120, 1);
      exp_seg(5, 9, 240, 130);
    end
    check_segs("preempt", PREEMPT ? 1 : 2);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
